aes_block_packer: RTL and testbench

AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

---
 rtl/aes_block_packer_pkg.sv | 28 ++
 rtl/aes_block_packer_bswap.sv | 15 +
 rtl/aes_block_packer.sv | 111 +++++++++++
 tb/tb_aes_block_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_block_packer_pkg.sv
// Shared widths and issue-FSM encoding for the AES block packer.
package aes_block_packer_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = AES_BLK_W / WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_NEXT,
    ST_BUSY
  } iss_state_e;

  // Writing slot 0 clears the rest of the block, so a padded tail is
  // already zero-filled when the block is closed early.
  function automatic logic [AES_BLK_W-1:0] place_word(
    input logic [AES_BLK_W-1:0] blk,
    input logic [1:0]           slot,
    input logic [WORD_W-1:0]    w
  );
    logic [AES_BLK_W-1:0] r;
    r = (slot == 2'd0) ? '0 : blk;
    r[AES_BLK_W-1-WORD_W*int'(slot) -: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/aes_block_packer_bswap.sv
// Combinational byte reversal of one 32-bit word.
module aes_word_bswap
  import aes_block_packer_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam int NB = WORD_W / 8;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign dout[8*i +: 8] = din[8*(NB-1-i) +: 8];
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into 128-bit ping-pong blocks and hands them to an AES core.
// Define AES_PACK_PAD_EN to zero-pad a block closed early by s_tlast (else it is dropped and pad_err set).
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int BSWAP = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [WORD_W-1:0]    s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic                 key_ready,
  input  logic                 block_ready,
  output logic                 next,
  output logic [AES_BLK_W-1:0] input_block,
  output logic                 pad_err,
  output logic [15:0]          blk_cnt
);

  logic [1:0][AES_BLK_W-1:0] buf_q;
  logic [1:0]                full_q;
  logic                      fill_sel;
  logic                      iss_sel;
  logic [1:0]                wcnt;
  logic                      br_q;
  iss_state_e                state, state_nx;

  logic [WORD_W-1:0] word;
  logic acc, last_slot, blk_done, pad_hit, br_rise, iss_free;

  if (BSWAP != 0) begin : g_bswap
    aes_word_bswap u_bswap (.din(s_tdata), .dout(word));
  end else begin : g_pass
    assign word = s_tdata;
  end

  assign s_tready  = ~full_q[fill_sel];
  assign acc       = s_tvalid & s_tready;
  assign last_slot = (wcnt == 2'd3);

`ifdef AES_PACK_PAD_EN
  assign blk_done = acc & (last_slot | s_tlast);
  assign pad_hit  = 1'b0;
`else
  assign blk_done = acc & last_slot;
  assign pad_hit  = acc & s_tlast & ~last_slot;
`endif

  assign br_rise  = block_ready & ~br_q;
  assign iss_free = (state == ST_BUSY) & br_rise;

  // Fill and free always target different buffers: the fill side is never
  // full, the issued side always is, so both updates can land together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_q    <= '0;
      full_q   <= '0;
      fill_sel <= 1'b0;
      iss_sel  <= 1'b0;
      wcnt     <= 2'd0;
      pad_err  <= 1'b0;
    end else begin
      if (acc) begin
        buf_q[fill_sel] <= place_word(buf_q[fill_sel], wcnt, word);
        wcnt            <= (blk_done | pad_hit) ? 2'd0 : wcnt + 2'd1;
      end
      if (blk_done) begin
        full_q[fill_sel] <= 1'b1;
        fill_sel         <= ~fill_sel;
      end
      if (iss_free) begin
        full_q[iss_sel] <= 1'b0;
        iss_sel         <= ~iss_sel;
      end
      if (pad_hit) pad_err <= 1'b1;
    end
  end

  // input_block is captured on entry to NEXT and held until the next issue.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      br_q        <= 1'b0;
      blk_cnt     <= 16'd0;
      input_block <= '0;
    end else begin
      state <= state_nx;
      br_q  <= block_ready;
      if (iss_free) blk_cnt <= blk_cnt + 16'd1;
      if (state == ST_WAIT_KEY && key_ready) input_block <= buf_q[iss_sel];
    end
  end

  always_comb begin
    state_nx = state;
    next     = 1'b0;
    case (state)
      ST_IDLE:     if (full_q[iss_sel]) state_nx = ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_ready) state_nx = ST_NEXT;
      ST_NEXT: begin
        next     = 1'b1;
        state_nx = ST_BUSY;
      end
      ST_BUSY:     if (br_rise) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: plain and byte-swapped instances share stimulus.
module tb_aes_block_packer;

`ifdef AES_PACK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         aclk, areset;
  logic [31:0]  s_tdata;
  logic         s_tvalid, s_tlast, key_ready, block_ready;
  logic         s_tready, next, pad_err;
  logic [127:0] input_block;
  logic [15:0]  blk_cnt;
  logic         s_tready2, next2, pad_err2;
  logic [127:0] input_block2;
  logic [15:0]  blk_cnt2;

  aes_block_packer #(.BSWAP(0)) dut (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast), .key_ready(key_ready),
    .block_ready(block_ready), .next(next), .input_block(input_block),
    .pad_err(pad_err), .blk_cnt(blk_cnt));

  aes_block_packer #(.BSWAP(1)) dut_sw (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready2), .s_tlast(s_tlast), .key_ready(key_ready),
    .block_ready(block_ready), .next(next2), .input_block(input_block2),
    .pad_err(pad_err2), .blk_cnt(blk_cnt2));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0, checks = 0;
  logic [31:0]  part[$];
  logic [127:0] expq[$], expq2[$];
  int exp_cnt = 0;
  bit exp_pad = 0;
  bit core_hold = 0, core_abort = 0, rand_key = 0;
  int core_lat;
  bit core_ab;
  logic [127:0] last1, last2;
  bit hold1 = 0, hold2 = 0, prev1 = 0, prev2 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or event missing", nm);
  endtask

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reference: group accepted words into fours; a short group ended by
  // s_tlast is either zero-padded or dropped with a sticky error.
  task automatic model_accept(input logic [31:0] w, input logic last);
    logic [127:0] b1, b2;
    part.push_back(w);
    if (part.size() == 4 || last) begin
      if (part.size() == 4 || PAD) begin
        while (part.size() < 4) part.push_back(32'h0);
        b1 = '0;
        b2 = '0;
        foreach (part[i]) begin
          b1 = {b1[95:0], part[i]};
          b2 = {b2[95:0], bswap32(part[i])};
        end
        expq.push_back(b1);
        expq2.push_back(b2);
      end else begin
        exp_pad = 1'b1;
      end
      part.delete();
    end
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int n;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = w;
    s_tlast  = last;
    if (rand_key) key_ready = ($urandom_range(0, 3) != 0);
    n = 0;
    while (!s_tready && n < 1000) begin
      @(negedge aclk);
      n++;
      if (rand_key) key_ready = ($urandom_range(0, 3) != 0);
    end
    if (!s_tready) begin
      fail("send_timeout");
      s_tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    model_accept(w, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    idle(1);
    rand_key  = 0;
    key_ready = 1'b1;
    core_hold = 0;
    n = 0;
    while ((expq.size() != 0 || expq2.size() != 0) && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (expq.size() != 0 || expq2.size() != 0) fail({nm, "_drain"});
    repeat (20) @(negedge aclk);
    chk({nm, "_blk_cnt"}, blk_cnt, exp_cnt[15:0]);
    chk({nm, "_blk_cnt_sw"}, blk_cnt2, exp_cnt[15:0]);
    chk({nm, "_pad_err"}, pad_err, exp_pad);
    chk({nm, "_pad_err_sw"}, pad_err2, exp_pad);
  endtask

  // Core model: answers each next with a block_ready pulse after a random latency.
  initial begin
    block_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (next === 1'b1) begin
        core_lat = $urandom_range(1, 6);
        core_ab  = 0;
        for (int i = 0; i < core_lat || core_hold; i++) begin
          @(negedge aclk);
          if (core_abort) begin
            core_ab = 1;
            break;
          end
        end
        if (!core_ab) begin
          block_ready = 1'b1;
          exp_cnt++;
          @(negedge aclk);
          block_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: every next pulse pops one expected block per instance.
  initial begin
    forever begin
      @(negedge aclk);
      if (hold1) begin chk("input_block_hold", input_block, last1); hold1 = 0; end
      if (hold2) begin chk("input_block_hold_sw", input_block2, last2); hold2 = 0; end
      if (next === 1'b1) begin
        chk("next_width", prev1, 1'b0);
        if (expq.size() == 0) fail("unexpected_next");
        else begin
          last1 = expq.pop_front();
          chk("input_block", input_block, last1);
          hold1 = 1;
        end
      end
      if (next2 === 1'b1) begin
        chk("next_width_sw", prev2, 1'b0);
        if (expq2.size() == 0) fail("unexpected_next_sw");
        else begin
          last2 = expq2.pop_front();
          chk("input_block_sw", input_block2, last2);
          hold2 = 1;
        end
      end
      prev1 = next;
      prev2 = next2;
    end
  end

  initial begin
    int n;
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; key_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_next", next, 1'b0);
    chk("rst_input_block", input_block, 128'h0);
    chk("rst_blk_cnt", blk_cnt, 16'h0);
    chk("rst_pad_err", pad_err, 1'b0);
    chk("rst_tready", s_tready, 1'b1);
    areset = 1'b0;

    // Eight words against a stalled core: fill side fills up, second block waits.
    core_hold = 1;
    for (int i = 0; i < 8; i++) send($urandom, 1'b0);
    idle(1);
    chk("stall_tready", s_tready, 1'b0);
    chk("stall_tready_sw", s_tready2, 1'b0);
    repeat (10) @(negedge aclk);
    chk("stall_second_pending", expq.size(), 1);
    drain("b2b");
    chk("b2b_blk_cnt_is_2", blk_cnt, 16'd2);

    // Directed block.
    send(32'h00112233, 1'b0); send(32'h44556677, 1'b0);
    send(32'h8899AABB, 1'b0); send(32'hCCDDEEFF, 1'b1);
    drain("directed");

    // key_ready held low with a full buffer.
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 1'b0);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      chk("keywait_no_next", next, 1'b0);
    end
    key_ready = 1'b1;
    @(negedge aclk);
    chk("keywait_next_after_rise", next, 1'b1);
    drain("keywait");

    // Short message ended by s_tlast on the third word.
    send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b1);
    drain("short");

    // Byte-swap position 0.
    send(32'h01020304, 1'b0); send(32'h05060708, 1'b0);
    send(32'h090A0B0C, 1'b0); send(32'h0D0E0F10, 1'b0);
    drain("bswap");

    // Random traffic: gaps, random tlast, random key_ready.
    rand_key = 1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain("random");

    // Reset while BUSY with a partial block queued behind it.
    core_hold = 1;
    for (int i = 0; i < 6; i++) send($urandom, 1'b0);
    idle(1);
    n = 0;
    while (expq.size() != 0 && n < 100) begin @(negedge aclk); n++; end
    if (expq.size() != 0) fail("busy_reach");
    repeat (3) @(negedge aclk);
    core_abort = 1;
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("arst_next", next, 1'b0);
    chk("arst_input_block", input_block, 128'h0);
    chk("arst_blk_cnt", blk_cnt, 16'h0);
    chk("arst_pad_err", pad_err, 1'b0);
    chk("arst_input_block_sw", input_block2, 128'h0);
    part.delete(); expq.delete(); expq2.delete();
    exp_cnt = 0; exp_pad = 0;
    @(negedge aclk); @(negedge aclk);
    areset = 1'b0;
    core_hold = 0;
    @(negedge aclk);
    core_abort = 0;
    chk("arst_tready_after", s_tready, 1'b1);
    for (int i = 0; i < 4; i++) send($urandom, 1'b0);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
